// File: rtl/timer_pkg.sv
// Shared encodings for the timer control stage: FSM states, register map
// and CTRL bit positions.
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_LOAD    = 2'd1;
    localparam logic [1:0] ADDR_COMPARE = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_ONESHOT   = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int CTRL_PRESC_LSB = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-(presc+1) tick generator; cleared while the FSM is in START.
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] cnt;

    assign tick = run && (cnt == presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + ONE;
    end

endmodule

// File: rtl/timer_ctrl.sv
// Register-mapped control stage for the timer counter: CTRL/LOAD/COMPARE/STATUS,
// run FSM, prescaled count enable, reload pulse and sticky overflow interrupt.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        wrEn,
    input  logic [31:0] wrData,
    output logic [31:0] rdData,
    input  logic        co,
    output logic [31:0] initialLoad,
    output logic [31:0] coValLoad,
    output logic        init,
    output logic        cntEn,
    output logic        irq
);

    logic               en;
    logic               oneshot;
    logic               irq_en;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        load_r;
    logic [31:0]        cmp_r;
    logic               ovf;
    logic [1:0]         state;
    logic [1:0]         next_state;
    logic               tick;

    logic ctrl_wr, wr_en_bit, qco, os_done;

    assign ctrl_wr   = wrEn && (addr == ADDR_CTRL);
    assign wr_en_bit = wrData[CTRL_EN];
    // co from the counter is only meaningful while it is actually counting
    assign qco       = (state == ST_RUN) && co;
    assign os_done   = qco && oneshot;

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (ctrl_wr && wr_en_bit) next_state = ST_START;
            ST_START: next_state = (ctrl_wr && !wr_en_bit) ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                // a CTRL write overrides the one-shot termination in the same cycle
                if (ctrl_wr)
                    next_state = wr_en_bit ? (os_done ? ST_START : ST_RUN) : ST_IDLE;
                else if (os_done)
                    next_state = ST_DONE;
            end
            ST_DONE:  if (ctrl_wr) next_state = wr_en_bit ? ST_START : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            en      <= 1'b0;
            oneshot <= 1'b0;
            irq_en  <= 1'b0;
            presc   <= '0;
            load_r  <= '0;
            cmp_r   <= '0;
            ovf     <= 1'b0;
        end else begin
            state <= next_state;
            if (ctrl_wr) begin
                en      <= wrData[CTRL_EN];
                oneshot <= wrData[CTRL_ONESHOT];
                irq_en  <= wrData[CTRL_IRQ_EN];
                presc   <= wrData[CTRL_PRESC_LSB +: PRESC_W];
            end else if (os_done) begin
                en <= 1'b0;
            end
            if (wrEn && addr == ADDR_LOAD)    load_r <= wrData;
            if (wrEn && addr == ADDR_COMPARE) cmp_r  <= wrData;
            // set has priority over the W1C clear
            if (qco)
                ovf <= 1'b1;
            else if (wrEn && addr == ADDR_STATUS && wrData[0])
                ovf <= 1'b0;
        end
    end

    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == ST_START),
        .run   (state == ST_RUN),
        .presc (presc),
        .tick  (tick)
    );

    assign init        = (state == ST_START);
    assign cntEn       = tick;
    assign irq         = ovf && irq_en;
    assign initialLoad = load_r;
    assign coValLoad   = cmp_r;

    always_comb begin
        rdData = '0;
        unique case (addr)
            ADDR_CTRL: begin
                rdData[CTRL_EN]                      = en;
                rdData[CTRL_ONESHOT]                 = oneshot;
                rdData[CTRL_IRQ_EN]                  = irq_en;
                rdData[CTRL_PRESC_LSB +: PRESC_W]    = presc;
            end
            ADDR_LOAD:    rdData = load_r;
            ADDR_COMPARE: rdData = cmp_r;
            ADDR_STATUS:  rdData[2:0] = {state, ovf};
            default:      rdData = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed + randomized bench for timer_ctrl with a behavioural register/FSM
// model and an attached up-counter model that drives co.
module tb_timer_ctrl;

    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = '0;
    logic        wrEn = 1'b0;
    logic [31:0] wrData = '0;
    logic        co = 1'b0;
    logic [31:0] rdData, initialLoad, coValLoad;
    logic        init, cntEn, irq;

    timer_ctrl #(.PRESC_W(PW)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wrEn(wrEn), .wrData(wrData),
        .rdData(rdData), .co(co), .initialLoad(initialLoad), .coValLoad(coValLoad),
        .init(init), .cntEn(cntEn), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: mode 0 idle, 1 start, 2 run, 3 done
    int          m_st;
    bit          m_en, m_os, m_ie, m_ovf;
    logic [7:0]  m_presc;
    int          m_pc;
    logic [31:0] m_load, m_cmp, m_cnt;
    bit          co_rand = 0;

    logic [1:0]  rd_addr = 2'd3;
    logic [31:0] last_rd;
    bit          last_irq;
    int          cen_cnt = 0, init_cnt = 0;

    task automatic model_reset();
        m_st = 0; m_en = 0; m_os = 0; m_ie = 0; m_ovf = 0;
        m_presc = '0; m_pc = 0; m_load = '0; m_cmp = '0; m_cnt = '0;
    endtask

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: begin v[0] = m_en; v[1] = m_os; v[2] = m_ie; v[15:8] = m_presc; end
            2'd1: v = m_load;
            2'd2: v = m_cmp;
            default: v = 32'(m_st * 2 + int'(m_ovf));
        endcase
        return v;
    endfunction

    // one clock cycle: drive at negedge, check, advance model, wait next negedge
    task automatic cyc(input bit we, input logic [1:0] a, input logic [31:0] d);
        bit c, qco, cw, e_init, e_cen;
        int ns;
        c = co_rand ? bit'($urandom_range(0, 1)) : (m_cnt == m_cmp);
        addr = a; wrEn = we; wrData = d; co = c;
        #1;
        e_init = (m_st == 1);
        e_cen  = (m_st == 2) && (m_pc == int'(m_presc));
        chk("init", {31'b0, init}, {31'b0, e_init});
        chk("cntEn", {31'b0, cntEn}, {31'b0, e_cen});
        chk("irq", {31'b0, irq}, {31'b0, m_ovf & m_ie});
        chk("rdData", rdData, m_rd(a));
        chk("initialLoad", initialLoad, m_load);
        chk("coValLoad", coValLoad, m_cmp);
        last_rd = rdData; last_irq = irq;
        cen_cnt += int'(cntEn); init_cnt += int'(init);

        qco = (m_st == 2) && c;
        cw  = we && (a == 2'd0);
        ns  = m_st;
        case (m_st)
            0: if (cw && d[0]) ns = 1;
            1: ns = (cw && !d[0]) ? 0 : 2;
            2: if (cw) ns = !d[0] ? 0 : ((qco && m_os) ? 1 : 2);
               else if (qco && m_os) ns = 3;
            default: if (cw) ns = d[0] ? 1 : 0;
        endcase
        if (e_init) m_cnt = m_load;
        else if (e_cen) m_cnt = (m_cnt == m_cmp) ? m_load : m_cnt + 32'd1;
        if (m_st == 1) m_pc = 0;
        else if (m_st == 2) m_pc = e_cen ? 0 : (m_pc + 1) % 256;
        if (qco) m_ovf = 1;
        else if (we && a == 2'd3 && d[0]) m_ovf = 0;
        if (cw) begin
            m_en = d[0]; m_os = d[1]; m_ie = d[2]; m_presc = d[15:8];
        end else if (qco && m_os) begin
            m_en = 0;
        end
        if (we && a == 2'd1) m_load = d;
        if (we && a == 2'd2) m_cmp = d;
        m_st = ns;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, rd_addr, 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_init"}, {31'b0, init}, 32'd0);
        chk({tag, "_cntEn"}, {31'b0, cntEn}, 32'd0);
        chk({tag, "_irq"}, {31'b0, irq}, 32'd0);
        chk({tag, "_rd"}, rdData, 32'd0);
        chk({tag, "_load"}, initialLoad, 32'd0);
        chk({tag, "_cmp"}, coValLoad, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  a;
        model_reset();
        #1 reset_checks("por");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // LOAD=5 COMPARE=8 PRESC=0 periodic with IRQ_EN
        wr(2'd1, 32'd5); wr(2'd2, 32'd8); wr(2'd0, 32'h5);
        init_cnt = 0; cen_cnt = 0;
        idle(1);
        chk("main_init_pulse", 32'(init_cnt), 32'd1);
        idle(3);
        chk("main_irq_before_co", {31'b0, last_irq}, 32'd0);
        idle(2);
        chk("main_irq_after_co", {31'b0, last_irq}, 32'd1);
        chk("main_ovf", last_rd & 32'h1, 32'd1);
        chk("main_cnten_every", 32'(cen_cnt), 32'd5);
        chk("main_single_init", 32'(init_cnt), 32'd1);
        wr(2'd0, 32'h0); wr(2'd3, 32'h1);
        idle(1);
        chk("stop_status", last_rd, 32'd0);

        // PRESC=3 periodic: 1 pulse in 4, first on 4th RUN cycle
        wr(2'd1, 32'd0); wr(2'd2, 32'd1000); wr(2'd0, 32'h301);
        idle(1);
        cen_cnt = 0; idle(3);
        chk("presc3_first3", 32'(cen_cnt), 32'd0);
        cen_cnt = 0; idle(13);
        chk("presc3_pulses", 32'(cen_cnt), 32'd4);

        // asynchronous reset mid-RUN
        wr(2'd1, 32'd5); idle(2);
        #2; addr = 2'd0; wrEn = 1'b0; rst = 1'b1;
        #1 reset_checks("arst");
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        rd_addr = 2'd3; cen_cnt = 0; init_cnt = 0;
        idle(6);
        chk("arst_no_cnten", 32'(cen_cnt + init_cnt), 32'd0);
        chk("arst_status", last_rd, 32'd0);

        // one-shot: LOAD=0 COMPARE=2
        wr(2'd1, 32'd0); wr(2'd2, 32'd2); wr(2'd0, 32'h3);
        idle(5);
        idle(1);
        chk("os_status", last_rd, 32'h7);
        rd_addr = 2'd0; idle(1);
        chk("os_ctrl_en_clr", last_rd, 32'h2);
        cen_cnt = 0; idle(20);
        chk("os_no_cnten", 32'(cen_cnt), 32'd0);
        init_cnt = 0; wr(2'd0, 32'h3); idle(1);
        chk("os_restart_init", 32'(init_cnt), 32'd1);
        wr(2'd0, 32'h0);

        // W1C racing a continuous co (LOAD == COMPARE)
        rd_addr = 2'd3;
        wr(2'd3, 32'h1); wr(2'd1, 32'd7); wr(2'd2, 32'd7); wr(2'd0, 32'h5);
        idle(2);
        wr(2'd3, 32'h1);
        idle(1);
        chk("w1c_set_wins", last_rd & 32'h1, 32'd1);
        chk("w1c_set_wins_irq", {31'b0, last_irq}, 32'd1);
        wr(2'd0, 32'h4); wr(2'd3, 32'h1);
        idle(1);
        chk("w1c_clear", last_rd, 32'd0);
        chk("w1c_clear_irq", {31'b0, last_irq}, 32'd0);

        // EN=0 mid-RUN with PRESC=2, then restart
        wr(2'd1, 32'd0); wr(2'd2, 32'd1000); wr(2'd0, 32'h201);
        idle(5);
        wr(2'd0, 32'h200);
        cen_cnt = 0; init_cnt = 0; idle(3);
        chk("stop_no_cnten", 32'(cen_cnt), 32'd0);
        chk("stop_no_init", 32'(init_cnt), 32'd0);
        chk("stop_state", last_rd, 32'd0);
        init_cnt = 0; wr(2'd0, 32'h201); idle(1);
        chk("restart_init", 32'(init_cnt), 32'd1);
        cen_cnt = 0; idle(2);
        chk("restart_first2", 32'(cen_cnt), 32'd0);
        idle(1);
        chk("restart_third", 32'(cen_cnt), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) co_rand = !co_rand;
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 30) begin
                d = $urandom;
                if (a == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
                if ((a == 2'd1 || a == 2'd2) && $urandom_range(0, 9) != 0)
                    d = 32'($urandom_range(0, 7));
                cyc(1'b1, a, d);
            end else begin
                cyc(1'b0, a, 32'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Register-mapped control stage that drives the timer counter and consumes its carry-out.
- Holds the software-visible LOAD, COMPARE and CTRL registers and generates the prescaled count enable (`cntEn`) and the one-cycle `init` pulse.
- Captures `co` into a sticky overflow flag and drives the interrupt line.
- Supports periodic (auto-reload) and one-shot modes.

Parameters:
- PRESC_W, 8, prescaler width; legal range 1..24. Divide ratio = PRESC+1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- addr  in  2  register select: 0=CTRL, 1=LOAD, 2=COMPARE, 3=STATUS
- wrEn  in  1  register write strobe, single cycle
- wrData  in  32  write data
- rdData  out  32  combinational read of the register at addr
- co  in  1  carry-out from the timer counter
- initialLoad  out  32  LOAD register value
- coValLoad  out  32  COMPARE register value
- init  out  1  counter reload pulse
- cntEn  out  1  counter increment enable
- irq  out  1  interrupt request

Behaviour:
- Reset:
  - Forces all registers, the prescaler, flag and FSM to 0/IDLE.
  - initialLoad, coValLoad, init, cntEn, irq and rdData (addr 0) all read 0.
- CTRL layout:
  - bit0 EN, bit1 ONESHOT, bit2 IRQ_EN.
  - bits [8+PRESC_W-1:8] PRESC.
  - Other bits read 0.
- STATUS layout:
  - bit0 OVF flag, bits[2:1] FSM state; read-only except OVF.
  - Writing 1 to bit0 clears OVF; writing 0 has no effect.
- Writes take effect at the clock edge. LOAD and COMPARE drive their outputs directly, so changes apply immediately, including while running.
- FSM states: IDLE=0, START=1, RUN=2, DONE=3.
- IDLE:
  - cntEn=0, init=0.
  - CTRL write with EN=1 -> START.
- START:
  - Lasts exactly one cycle, with init=1.
  - Prescaler cleared to 0; cntEn=0.
  - Next state is RUN, unless the same cycle has a CTRL write with EN=0, in which case -> IDLE.
- RUN:
  - Prescaler increments each cycle. When prescaler==PRESC, cntEn=1 for that cycle and the prescaler wraps to 0.
  - PRESC=0 gives cntEn=1 every cycle.
- co handling:
  - co is qualified only in RUN. It is ignored in IDLE, START and DONE, including the post-reset case where the counter and COMPARE are both 0.
  - Qualified co sets OVF.
  - If ONESHOT=1: -> DONE, the EN bit self-clears, and cntEn=0 from that cycle's next edge onward.
  - If ONESHOT=0: stay in RUN; the counter reloads itself on co.
- CTRL write with EN=0 in RUN or START -> IDLE. cntEn drops the next cycle, no init is issued, and the counter holds its value.
- CTRL write with EN=1 in RUN: no restart; only ONESHOT, IRQ_EN and PRESC update.
- DONE:
  - cntEn=0.
  - CTRL write with EN=1 -> START (restart).
  - CTRL write with EN=0 -> IDLE.
- Simultaneous qualified co and W1C of OVF: set wins, OVF stays 1.
- Simultaneous one-shot co and a CTRL write with EN=1: the write wins, FSM -> START and OVF is set.
- If initialLoad==coValLoad, co may stay high continuously. OVF then re-sets every RUN cycle; a one-shot still terminates on the first RUN cycle.
- irq = OVF & IRQ_EN. It is combinational from registered bits, so no extra latency.
- Latency:
  - CTRL write with EN=1 at edge T: init is high during cycle T..T+1, and the first cntEn is possible at cycle T+1..T+2.
  - co in cycle N: OVF is visible in STATUS from edge N+1.

Decomposition:
- Shared package timer_pkg holds:
  - FSM state encoding.
  - Register address constants (CTRL/LOAD/COMPARE/STATUS).
  - CTRL bit positions (EN, ONESHOT, IRQ_EN, PRESC_LSB).
- One natural sub-module, timer_prescaler:
  - Inputs: clk, rst, clr, run, presc[PRESC_W-1:0].
  - Output: tick.
  - The register file, FSM and flag logic stay in timer_ctrl.

Test Plan:
- Reset asserted mid-RUN with PRESC=3 -> all outputs 0 in the same cycle (asynchronous); STATUS reads 0; after release, no cntEn until EN is written.
- LOAD=5, COMPARE=8, PRESC=0, CTRL=0x5 (EN, IRQ_EN) with the timer counter attached:
  - init high for exactly one cycle after the write, then cntEn every cycle.
  - co every 4 cycles (5,6,7,8).
  - OVF=1 and irq=1 from the first co.
- PRESC=3, periodic -> cntEn high exactly 1 cycle in 4, with the first cntEn on the 4th RUN cycle; 16 RUN cycles give 4 pulses.
- ONESHOT: CTRL=0x3, LOAD=0, COMPARE=2, PRESC=0:
  - After the first co, STATUS reads 0x7 (DONE, OVF) and CTRL bit0 reads 0.
  - cntEn stays 0 for 20 cycles.
  - Rewriting EN=1 produces a new init pulse.
- W1C: STATUS write 0x1 in the same cycle as a qualified co -> OVF stays 1. STATUS write 0x1 with no co -> OVF=0 and irq=0 next cycle.
- CTRL write EN=0 mid-RUN with PRESC=2:
  - cntEn=0 from the next cycle, no init, STATUS state=0.
  - Re-enable -> init pulse, and the prescaler restarts from 0 (first cntEn on the 3rd RUN cycle).
